// File: rtl/pattern_response_compactor_if.sv
// pattern_response_compactor_if
//   Bundles the window-control, response-sample and result-handshake
//   signals of the response compactor.
//   master : the producer/consumer side. It drives start, abort, seed,
//            window_len, resp_in, resp_valid and sig_ready, and observes
//            the result.
//   slave  : the compactor itself. It drives busy, sig_out, act_mask,
//            sample_cnt and sig_valid.
interface pattern_response_compactor_if #(
  parameter int IN_W  = 9,
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] seed;
  logic [CNT_W-1:0] window_len;
  logic [IN_W-1:0]  resp_in;
  logic             resp_valid;
  logic             busy;
  logic [SIG_W-1:0] sig_out;
  logic [IN_W-1:0]  act_mask;
  logic [CNT_W-1:0] sample_cnt;
  logic             sig_valid;
  logic             sig_ready;

  modport master (
    output start, abort, seed, window_len, resp_in, resp_valid, sig_ready,
    input  busy, sig_out, act_mask, sample_cnt, sig_valid
  );

  modport slave (
    input  start, abort, seed, window_len, resp_in, resp_valid, sig_ready,
    output busy, sig_out, act_mask, sample_cnt, sig_valid
  );
endinterface

// File: rtl/pattern_response_compactor.sv
// pattern_response_compactor
//   Compacts a stream of IN_W-bit response vectors into a SIG_W-bit MISR/CRC
//   signature over a window of window_len accepted samples. It also records
//   which response bits toggled between consecutive samples. The result is
//   offered through a valid/ready handshake.
//   blif_clk_net   : clock, rising edge
//   blif_reset_net : synchronous active-low reset
//   bus (slave)    : start/abort/seed/window_len control, resp_in/resp_valid
//                    samples, and the busy/sig_out/act_mask/sample_cnt/
//                    sig_valid/sig_ready result handshake
//   Every output is a register. No input reaches an output combinationally.
module pattern_response_compactor #(
  parameter int               IN_W  = 9,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter int               CNT_W = 16
) (
  input logic                          blif_clk_net,
  input logic                          blif_reset_net,
  pattern_response_compactor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] len, cnt;
  logic [IN_W-1:0]  mask, prev;
  logic             have_prev;

  logic [SIG_W-1:0] sig_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IN_W-1:0]  mask_nxt;
  logic             last;

  // Next-state values for the sample being accepted this cycle.
  always_comb begin
    sig_nxt  = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(bus.resp_in);
    cnt_nxt  = cnt + CNT_W'(1);
    mask_nxt = have_prev ? (mask | (bus.resp_in ^ prev)) : mask;
    // cnt stays below len while in RUN, so this equality is the only
    // terminal test. It is safe even when len is the counter's maximum.
    last     = (cnt_nxt == len);
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state          <= IDLE;
      sig            <= '0;
      len            <= '0;
      cnt            <= '0;
      mask           <= '0;
      prev           <= '0;
      have_prev      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sig_out    <= '0;
      bus.act_mask   <= '0;
      bus.sample_cnt <= '0;
      bus.sig_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sig       <= bus.seed;
            len       <= bus.window_len;
            cnt       <= '0;
            mask      <= '0;
            have_prev <= 1'b0;
            bus.busy  <= 1'b1;
            if (bus.window_len == '0) begin
              // An empty window completes at once. The result is the seed.
              state          <= HOLD;
              bus.sig_out    <= bus.seed;
              bus.act_mask   <= '0;
              bus.sample_cnt <= '0;
              bus.sig_valid  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (bus.resp_valid) begin
            sig       <= sig_nxt;
            cnt       <= cnt_nxt;
            mask      <= mask_nxt;
            prev      <= bus.resp_in;
            have_prev <= 1'b1;
            if (last) begin
              state          <= HOLD;
              bus.sig_out    <= sig_nxt;
              bus.act_mask   <= mask_nxt;
              bus.sample_cnt <= cnt_nxt;
              bus.sig_valid  <= 1'b1;
            end
          end
        end
        HOLD: begin
          // sig_valid is always high in HOLD, so sig_ready alone completes
          // the handshake. Any start seen in this cycle is dropped.
          if (bus.abort || bus.sig_ready) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.sig_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.sig_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_response_compactor.sv
module tb_pattern_response_compactor;

  logic clk;
  logic rst_n;

  pattern_response_compactor_if bus ();

  pattern_response_compactor dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A window is either inactive, collecting samples, or holding a result.
  // At completion the result is computed from the whole list of samples.
  bit          m_act, m_hold;
  int unsigned m_len;
  int unsigned m_seed;
  logic [8:0]  q[$];
  logic        exp_valid, exp_busy;
  logic [15:0] exp_sig;
  logic [8:0]  exp_mask;
  logic [15:0] exp_cnt;
  bit          chk_en = 0;

  task finish_window();
    int unsigned v;
    logic [8:0]  m;
    v = m_seed;
    foreach (q[i]) begin
      v = v * 2;
      if (v >= 65536) v = (v - 65536) ^ 32'h1021;
      v = v ^ 32'(q[i]);
    end
    m = '0;
    for (int i = 1; i < q.size(); i++) m = m | (q[i] ^ q[i-1]);
    exp_sig  = v[15:0];
    exp_mask = m;
    exp_cnt  = 16'(q.size());
    m_hold   = 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_hold = 0; q.delete();
      exp_sig = '0; exp_mask = '0; exp_cnt = '0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act  = 1;
        m_seed = 32'(bus.seed);
        m_len  = 32'(bus.window_len);
        q.delete();
        if (m_len == 0) finish_window();
      end
    end else if (bus.abort) begin
      m_act = 0; m_hold = 0;
    end else if (m_hold) begin
      if (bus.sig_ready) begin m_act = 0; m_hold = 0; end
    end else if (bus.resp_valid) begin
      q.push_back(bus.resp_in);
      if (q.size() == m_len) finish_window();
    end
    exp_busy  = m_act;
    exp_valid = m_hold;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_sig_valid", 32'(bus.sig_valid), 32'(exp_valid));
      chk("cyc_busy", 32'(bus.busy), 32'(exp_busy));
      if (exp_valid) begin
        chk("cyc_sig_out", 32'(bus.sig_out), 32'(exp_sig));
        chk("cyc_act_mask", 32'(bus.act_mask), 32'(exp_mask));
        chk("cyc_sample_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.seed = '0; bus.window_len = '0;
    bus.resp_in = '0; bus.resp_valid = 0; bus.sig_ready = 0;
  endtask

  task automatic begin_window(input logic [15:0] s, input logic [15:0] n);
    bus.start = 1; bus.seed = s; bus.window_len = n;
    step();
    bus.start = 0;
  endtask

  task automatic sample(input logic [8:0] r);
    bus.resp_in = r; bus.resp_valid = 1;
    step();
    bus.resp_valid = 0;
  endtask

  task automatic handshake();
    bus.sig_ready = 1;
    step();
    bus.sig_ready = 0;
  endtask

  logic [8:0] pat[3];
  bit         saw_valid;

  initial begin
    idle_inputs();
    // 1: reset with random inputs and start held high
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1; bus.abort = 1'($urandom); bus.seed = 16'($urandom);
      bus.window_len = 16'($urandom); bus.resp_in = 9'($urandom);
      bus.resp_valid = 1'($urandom); bus.sig_ready = 1'($urandom);
      step();
      chk_en = 1;
    end
    chk("rst_sig_valid", 32'(bus.sig_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_sig_out", 32'(bus.sig_out), 0);
    chk("rst_act_mask", 32'(bus.act_mask), 0);
    chk("rst_sample_cnt", 32'(bus.sample_cnt), 0);
    idle_inputs();
    rst_n = 1;
    step();

    // 2: single sample
    begin_window(16'h0000, 16'd1);
    chk("t2_busy_run", 32'(bus.busy), 1);
    sample(9'h1FF);
    chk("t2_valid", 32'(bus.sig_valid), 1);
    chk("t2_sig", 32'(bus.sig_out), 32'h01FF);
    chk("t2_cnt", 32'(bus.sample_cnt), 1);
    chk("t2_mask", 32'(bus.act_mask), 0);
    handshake();
    chk("t2_done_valid", 32'(bus.sig_valid), 0);

    // 3: feedback tap
    begin_window(16'h8000, 16'd1);
    sample(9'h000);
    chk("t3_sig", 32'(bus.sig_out), 32'h1021);
    handshake();

    // 4: stall and mask
    begin_window(16'h0000, 16'd2);
    sample(9'h001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_valid", 32'(bus.sig_valid), 0);
    end
    sample(9'h000);
    chk("t4_valid", 32'(bus.sig_valid), 1);
    chk("t4_sig", 32'(bus.sig_out), 32'h0002);
    chk("t4_mask", 32'(bus.act_mask), 32'h001);
    chk("t4_cnt", 32'(bus.sample_cnt), 2);
    handshake();

    // 5: backpressure in HOLD
    pat[0] = 9'h0A5; pat[1] = 9'h15A; pat[2] = 9'h0A5;
    begin_window(16'h1234, 16'd3);
    for (int i = 0; i < 3; i++) sample(pat[i]);
    for (int i = 0; i < 5; i++) begin
      bus.resp_valid = 1'(i % 2); bus.resp_in = 9'h1C3; bus.start = 1;
      step();
      chk("t5_hold_valid", 32'(bus.sig_valid), 1);
      chk("t5_hold_sig", 32'(bus.sig_out), 32'h9125);
      chk("t5_hold_mask", 32'(bus.act_mask), 32'h1FF);
      chk("t5_hold_cnt", 32'(bus.sample_cnt), 3);
    end
    bus.resp_valid = 0; bus.start = 0;
    handshake();
    chk("t5_rel_valid", 32'(bus.sig_valid), 0);
    chk("t5_rel_busy", 32'(bus.busy), 0);

    // 6a: abort mid-window
    begin_window(16'h0000, 16'd8);
    for (int i = 0; i < 3; i++) sample(9'(i + 3));
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk("t6a_busy", 32'(bus.busy), 0);
    saw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      bus.resp_in = 9'h055; bus.resp_valid = 1;
      step();
      if (bus.sig_valid) saw_valid = 1;
    end
    bus.resp_valid = 0;
    chk("t6a_never_valid", 32'(saw_valid), 0);

    // 6b: empty window
    begin_window(16'hBEEF, 16'd0);
    chk("t6b_valid", 32'(bus.sig_valid), 1);
    chk("t6b_sig", 32'(bus.sig_out), 32'hBEEF);
    chk("t6b_cnt", 32'(bus.sample_cnt), 0);
    // abort while holding drops the result
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk("t6b_abort_valid", 32'(bus.sig_valid), 0);

    // start and sig_ready held together: alternating restart pattern
    bus.start = 1; bus.seed = 16'hA5A5; bus.window_len = 16'd0; bus.sig_ready = 1;
    for (int i = 0; i < 6; i++) step();
    idle_inputs();
    step();

    // 6c: reset while holding
    begin_window(16'h0005, 16'd1);
    sample(9'h003);
    chk("t6c_pre_valid", 32'(bus.sig_valid), 1);
    rst_n = 0;
    step();
    chk("t6c_valid", 32'(bus.sig_valid), 0);
    chk("t6c_busy", 32'(bus.busy), 0);
    chk("t6c_sig", 32'(bus.sig_out), 0);
    rst_n = 1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_response_compactor.md
Name: pattern_response_compactor

Overview:
- Downstream observation stage for the pattern-merged graph netlists.
- Samples the 9-bit response vector those netlists produce and compacts it into a MISR/CRC signature over a programmable sample window.
- Tracks which response bits toggled during the window.
- Hands signature, activity mask and sample count to the checker through a valid/ready handshake.

Parameters:
- IN_W, 9: response vector width. Bit order: {G42_1, n_572_1, n_573_1, n_549_1, n_452_1, ACVQN2_3, n_266_and_0_3, ACVQN1_5, P6_5}, MSB first.
- SIG_W, 16: signature width. Must satisfy SIG_W >= IN_W.
- POLY, 16'h1021: feedback polynomial, SIG_W bits, implicit x^SIG_W term.
- CNT_W, 16: width of the window length and sample counter.

Ports:
- blif_clk_net, input, 1: the single clock; all state updates on rising edge.
- blif_reset_net, input, 1: reset, synchronous, active-low.
- start, input, 1: begin a window. Honoured in IDLE only.
- abort, input, 1: cancel the window. Honoured in RUN/HOLD.
- seed, input, SIG_W: initial signature, latched on accepted start.
- window_len, input, CNT_W: samples per window, latched on accepted start.
- resp_in, input, IN_W: response vector from the upstream netlist.
- resp_valid, input, 1: resp_in is valid this cycle.
- busy, output, 1: high in RUN or HOLD.
- sig_out, output, SIG_W: final signature, stable while sig_valid.
- act_mask, output, IN_W: bit i = 1 if resp_in[i] changed between any two consecutive accepted samples.
- sample_cnt, output, CNT_W: number of accepted samples in the window.
- sig_valid, output, 1: result available.
- sig_ready, input, 1: consumer accepts the result.

Behaviour:
- Reset: blif_reset_net=0 at a clock edge forces IDLE, clears all internal state, and zeroes sig_out, act_mask, sample_cnt, sig_valid, busy. Reset overrides every other input, including mid-window and mid-handshake.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - start=1 latches seed into sig, window_len into len; clears cnt, mask and have_prev.
  - Next state is RUN, or HOLD if window_len=0, in which case sig_out=seed and sample_cnt=0.
- RUN, on a cycle with resp_valid=1 (an accepted sample):
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
  - cnt <= cnt+1.
  - If have_prev, mask |= resp_in ^ prev.
  - prev <= resp_in; have_prev <= 1.
- RUN, resp_valid=0: all state holds (stall). No timeout.
- RUN -> HOLD: on the edge that accepts sample number len.
  - sig_valid=1 from the next cycle, with sig_out, act_mask and sample_cnt=len registered.
  - Latency from final sample to sig_valid is 1 cycle.
- HOLD:
  - sig_valid stays high; sig_out, act_mask and sample_cnt are stable until the handshake.
  - Inputs resp_valid and start are ignored.
  - sig_valid&sig_ready -> IDLE next cycle with sig_valid=0. Result outputs keep their values until the next start.
- sig_ready=1 during RUN or IDLE has no effect.
- abort=1 in RUN or HOLD -> IDLE next cycle with sig_valid=0; the partial result is discarded (outputs not updated). abort in IDLE is ignored.
- Same-cycle priority: reset > abort > handshake > sample.
  - start is ignored in the same cycle as the handshake; a new start is needed in IDLE.
  - A start held high continuously restarts from IDLE on the cycle after the handshake.
- cnt is never compared past len: the window ends exactly at len. len=2^CNT_W-1 is legal.
- busy = (state != IDLE), registered.
- No combinational path from any input to any output.

Test Plan:
1. Reset: drive all inputs random, blif_reset_net=0 for 2 cycles -> all outputs 0, busy=0; start held in the same cycles is ignored.
2. Single sample: seed=16'h0000, window_len=1, resp_in=9'h1FF valid 1 cycle -> sig_valid the next cycle, sig_out=16'h01FF, sample_cnt=1, act_mask=9'h000.
3. Feedback: seed=16'h8000, window_len=1, resp_in=0 -> sig_out=16'h1021.
4. Stall and mask: seed=0, window_len=2, samples 9'h001, then resp_valid=0 for 3 cycles, then 9'h000 -> sig_out=16'h0002, act_mask=9'h001, sample_cnt=2, sig_valid 1 cycle after the second sample.
5. Handshake backpressure: hold sig_ready=0 for 5 cycles in HOLD with resp_valid toggling -> outputs unchanged; sig_ready=1 -> sig_valid=0 and busy=0 next cycle.
6. Abort and edge cases:
   - abort in RUN after 3 of 8 samples -> IDLE, sig_valid never rises.
   - window_len=0 -> sig_valid 1 cycle after start with sig_out=seed.
   - Reset asserted in HOLD -> sig_valid=0 next cycle.
